// File: rtl/qdi_pkg.sv
// Shared definitions for the clocked QDI two-way arbiter.
//   state_e        : arbiter FSM states
//   NUM_CH         : number of request channels
//   DR_*           : dual-rail grant encodings (Rx[0] = channel 0, Rx[1] = channel 1)
//   dr_encode()    : maps a winning channel index to its dual-rail grant code
package qdi_pkg;

  localparam int NUM_CH = 2;

  localparam logic [1:0] DR_NULL = 2'b00;
  localparam logic [1:0] DR_0    = 2'b01;
  localparam logic [1:0] DR_1    = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    ACK     = 2'd2,
    RELEASE = 2'd3
  } state_e;

  function automatic logic [1:0] dr_encode(input logic ch);
    return ch ? DR_1 : DR_0;
  endfunction

endpackage

// File: rtl/qdi_input_sync.sv
// Synchronizer chain for one asynchronous handshake input.
//   clk   : sampling clock
//   srst  : synchronous active-high reset, clears every stage to 0
//   d_i   : asynchronous input
//   q_o   : synchronized output, STAGES cycles behind d_i
// With STAGES = 0 the input is already synchronous and passes straight through.
module qdi_input_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic srst,
  input  logic d_i,
  output logic q_o
);

  if (STAGES == 0) begin : g_bypass
    assign q_o = d_i;
  end else begin : g_chain
    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk) begin
      if (srst) begin
        chain_q <= '0;
      end else begin
        chain_q[0] <= d_i;
        for (int i = 1; i < STAGES; i++) begin
          chain_q[i] <= chain_q[i-1];
        end
      end
    end

    assign q_o = chain_q[STAGES-1];
  end

endmodule

// File: rtl/qdi_sync_arbiter.sv
// Clocked two-way arbiter standing in for an asynchronous QDI arbiter.
// Responder on two 1-of-1 request channels, initiator on a 1-of-2 dual-rail
// grant channel; every accepted request token yields one grant token.
//   CLK         : sole clock
//   RESET       : synchronous active-high reset
//   Tx[1:0]     : 1-of-1 request rails (async)
//   Txe[1:0]    : request-side enables, falling edge acknowledges a token
//   Rx[1:0]     : dual-rail grant, Rx[k]=1 means channel k won; never 2'b11
//   Rxe         : grant-side enable from the receiver (async)
//   GRANT_CNT0/1: per-channel grant counters, wrap modulo 2^CNT_W
//   PROTO_ERR   : sticky request-side protocol violation flag
module qdi_sync_arbiter
  import qdi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [1:0]       Tx,
  output logic [1:0]       Txe,
  output logic [1:0]       Rx,
  input  logic             Rxe,
  output logic [CNT_W-1:0] GRANT_CNT0,
  output logic [CNT_W-1:0] GRANT_CNT1,
  output logic             PROTO_ERR
);

  logic [NUM_CH-1:0] tx_s;
  logic              rxe_s;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_tx_sync
    qdi_input_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk  (CLK),
      .srst (RESET),
      .d_i  (Tx[gi]),
      .q_o  (tx_s[gi])
    );
  end

  qdi_input_sync #(.STAGES(SYNC_STAGES)) u_rxe_sync (
    .clk  (CLK),
    .srst (RESET),
    .d_i  (Rxe),
    .q_o  (rxe_s)
  );

  state_e            state_q, state_d;
  logic              w_q, w_d;        // winner of the grant in flight
  logic              last_q, last_d;  // most recent winner, for tie-breaks
  logic [1:0]        rx_q, rx_d;
  logic [NUM_CH-1:0] txe_q, txe_d;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic              err_q, err_d;
  logic [NUM_CH-1:0] tx_prev_q;       // synchronized Tx one cycle ago
  logic              pick;

  // Lone requester wins; on a tie the channel that did not win last time wins.
  assign pick = (tx_s == 2'b11) ? ~last_q : tx_s[1];

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    last_d  = last_q;
    rx_d    = rx_q;
    txe_d   = txe_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (rxe_s && (|tx_s)) begin
          rx_d    = dr_encode(pick);
          w_d     = pick;
          last_d  = pick;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!rxe_s) begin
          txe_d[w_q] = 1'b0;
          cnt_d[w_q] = cnt_q[w_q] + CNT_W'(1);
          state_d    = ACK;
        end
      end
      ACK: begin
        if (!tx_s[w_q]) begin
          rx_d    = DR_NULL;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (rxe_s) begin
          txe_d[w_q] = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A token may only be withdrawn after its Txe has fallen. The winner's Txe
    // stays high through GRANT, so the generic term also covers a winner
    // dropping early; the explicit GRANT term catches it even on the first
    // GRANT cycle.
    if ((state_q == GRANT && !tx_s[w_q]) || (|(txe_q & tx_prev_q & ~tx_s))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      w_q       <= 1'b0;
      last_q    <= 1'b1;
      rx_q      <= DR_NULL;
      txe_q     <= '1;
      cnt_q     <= '{default: '0};
      err_q     <= 1'b0;
      tx_prev_q <= '0;
    end else begin
      state_q   <= state_d;
      w_q       <= w_d;
      last_q    <= last_d;
      rx_q      <= rx_d;
      txe_q     <= txe_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      tx_prev_q <= tx_s;
    end
  end

  assign Txe        = txe_q;
  assign Rx         = rx_q;
  assign GRANT_CNT0 = cnt_q[0];
  assign GRANT_CNT1 = cnt_q[1];
  assign PROTO_ERR  = err_q;

endmodule

// File: tb/tb_qdi_sync_arbiter.sv
// Self-checking bench for qdi_sync_arbiter (SYNC_STAGES=2, CNT_W=4).
module tb_qdi_sync_arbiter;

  localparam int S = 2;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   tx  = 2'b00;
  logic         rxe = 1'b1;
  logic [1:0]   txe;
  logic [1:0]   rx;
  logic [W-1:0] cnt0;
  logic [W-1:0] cnt1;
  logic         err;

  int n_assert = 0;
  int n_fail   = 0;
  int grant_q[$];
  int mcnt[2];
  bit model_last;
  int n_grants = 0;

  typedef struct {
    logic [1:0] f_tx;
    logic       f_rxe;
    int         f_hold;
    logic [1:0] f_txe;
    logic [1:0] f_rx;
    int         f_c0;
    int         f_c1;
    logic       f_err;
  } vec_t;

  vec_t vecs[16];

  qdi_sync_arbiter #(.SYNC_STAGES(S), .CNT_W(W)) dut (
    .CLK        (clk),
    .RESET      (rst),
    .Tx         (tx),
    .Txe        (txe),
    .Rx         (rx),
    .Rxe        (rxe),
    .GRANT_CNT0 (cnt0),
    .GRANT_CNT1 (cnt1),
    .PROTO_ERR  (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic [1:0] t, input logic re, input int h,
                              input logic [1:0] te, input logic [1:0] r,
                              input int c0, input int c1);
    vec_t v;
    v.f_tx = t; v.f_rxe = re; v.f_hold = h; v.f_txe = te; v.f_rx = r;
    v.f_c0 = c0; v.f_c1 = c1; v.f_err = 1'b0;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    tx  = 2'b00;
    rxe = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_last = 1'b1;
    mcnt[0] = 0;
    mcnt[1] = 0;
    repeat (3) @(negedge clk);
  endtask

  // sel 0 waits on Rx, sel 1 waits on Txe
  task automatic wait_out(input string name, input int sel, input logic [1:0] val,
                          input int budget);
    logic [1:0] cur;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      cur = (sel == 0) ? rx : txe;
      if (cur == val) begin
        n_assert++;
        return;
      end
    end
    n_assert++;
    n_fail++;
    $display("FAIL %s: timeout after %0d cycles, got %b, expected %b", name, budget,
             (sel == 0) ? rx : txe, val);
  endtask

  // Token-level environment: n0/n1 tokens from the two transmitters, a
  // receiver that answers every grant; random response delays up to maxdly.
  // The expected winner is derived from which requests have been high long
  // enough to pass the synchronizers, and the arbitration rules.
  task automatic run_tokens(input int n0, input int n1, input int maxdly, input int budget);
    int rem[2];
    int dly[2];
    int age[2];
    int g[2];
    int rdly;
    bit seen;
    int cyc;
    int w;
    int expw;
    bit s0, s1;
    rem[0] = n0; rem[1] = n1;
    dly[0] = 0;  dly[1] = 0;
    age[0] = 0;  age[1] = 0;
    g[0]   = 0;  g[1]   = 0;
    rdly = 0; seen = 1'b0; cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      for (int k = 0; k < 2; k++) if (tx[k]) age[k]++;

      n_assert++;
      if (rx == 2'b11 || txe == 2'b00) begin
        n_fail++;
        $display("FAIL invariant: Rx=%b Txe=%b at cycle %0d", rx, txe, cyc);
      end

      if (rx != 2'b00 && !seen) begin
        seen = 1'b1;
        w  = int'(rx[1]);
        s0 = tx[0] && (age[0] >= S + 1);
        s1 = tx[1] && (age[1] >= S + 1);
        if (s0 && s1)  expw = model_last ? 0 : 1;
        else if (s1)   expw = 1;
        else if (s0)   expw = 0;
        else           expw = -1;
        check("grant_winner", w, expw);
        model_last = w[0];
        mcnt[w]++;
        g[w]++;
        grant_q.push_back(w);
        n_grants++;
        $display("grant %0d: channel %0d (Rx=%b)", n_grants, w, rx);
      end
      if (rx == 2'b00) seen = 1'b0;

      if ((rx != 2'b00 && rxe) || (rx == 2'b00 && !rxe)) begin
        if (rdly > 0) rdly--;
        else begin
          rxe  = ~rxe;
          rdly = $urandom_range(0, maxdly);
        end
      end

      for (int k = 0; k < 2; k++) begin
        if (tx[k] && !txe[k]) begin
          tx[k]  = 1'b0;
          rem[k] = rem[k] - 1;
          age[k] = 0;
        end else if (!tx[k] && txe[k] && rem[k] > 0) begin
          if (dly[k] > 0) dly[k]--;
          else begin
            tx[k]  = 1'b1;
            age[k] = 0;
            dly[k] = $urandom_range(0, maxdly);
          end
        end
      end

      if (rem[0] == 0 && rem[1] == 0 && tx == 2'b00 && rx == 2'b00 &&
          rxe && txe == 2'b11) break;
      if (cyc > budget) begin
        n_assert++;
        n_fail++;
        $display("FAIL run_timeout: %0d cycles, remaining %0d/%0d", cyc, rem[0], rem[1]);
        break;
      end
    end
    check("grants_ch0", g[0], n0);
    check("grants_ch1", g[1], n1);
    check("cnt0", int'(cnt0), mcnt[0] % (1 << W));
    check("cnt1", int'(cnt1), mcnt[1] % (1 << W));
    check("proto_err_clean", int'(err), 0);
  endtask

  initial begin
    logic [12:0] act;
    logic [12:0] exp;

    // Directed single-token timeline: each input is seen 1+S edges later.
    vecs[0]  = mk(2'b00, 1'b1,  1, 2'b11, 2'b00, 0, 0);
    vecs[1]  = mk(2'b01, 1'b1,  2, 2'b11, 2'b00, 0, 0);
    vecs[2]  = mk(2'b01, 1'b1,  1, 2'b11, 2'b01, 0, 0);
    vecs[3]  = mk(2'b01, 1'b0,  2, 2'b11, 2'b01, 0, 0);
    vecs[4]  = mk(2'b01, 1'b0,  1, 2'b10, 2'b01, 1, 0);
    vecs[5]  = mk(2'b00, 1'b0,  2, 2'b10, 2'b01, 1, 0);
    vecs[6]  = mk(2'b00, 1'b0,  1, 2'b10, 2'b00, 1, 0);
    vecs[7]  = mk(2'b00, 1'b1,  2, 2'b10, 2'b00, 1, 0);
    vecs[8]  = mk(2'b00, 1'b1,  1, 2'b11, 2'b00, 1, 0);
    // Receiver not ready: channel 1 must wait.
    vecs[9]  = mk(2'b10, 1'b0, 20, 2'b11, 2'b00, 1, 0);
    vecs[10] = mk(2'b10, 1'b1,  2, 2'b11, 2'b00, 1, 0);
    vecs[11] = mk(2'b10, 1'b1,  1, 2'b11, 2'b10, 1, 0);
    vecs[12] = mk(2'b10, 1'b0,  3, 2'b01, 2'b10, 1, 1);
    vecs[13] = mk(2'b00, 1'b0,  3, 2'b01, 2'b00, 1, 1);
    vecs[14] = mk(2'b00, 1'b1,  3, 2'b11, 2'b00, 1, 1);
    vecs[15] = mk(2'b01, 1'b1,  3, 2'b11, 2'b01, 1, 1);

    do_reset();
    for (int i = 0; i < 16; i++) begin
      tx  = vecs[i].f_tx;
      rxe = vecs[i].f_rxe;
      repeat (vecs[i].f_hold) @(posedge clk);
      @(negedge clk);
      act = {txe, rx, cnt0, cnt1, err};
      exp = {vecs[i].f_txe, vecs[i].f_rx, 4'(vecs[i].f_c0), 4'(vecs[i].f_c1), vecs[i].f_err};
      n_assert++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL vec%0d: got Txe=%b Rx=%b c0=%0d c1=%0d err=%b, expected Txe=%b Rx=%b c0=%0d c1=%0d err=%b",
                 i, txe, rx, cnt0, cnt1, err, vecs[i].f_txe, vecs[i].f_rx,
                 vecs[i].f_c0, vecs[i].f_c1, vecs[i].f_err);
      end else begin
        $display("vec %0d: Tx=%b Rxe=%b -> Txe=%b Rx=%b", i, tx, rxe, txe, rx);
      end
    end

    // Reset in the middle of a grant.
    do_reset();
    run_tokens(1, 0, 0, 500);
    tx  = 2'b01;
    rxe = 1'b1;
    wait_out("enter_grant", 0, 2'b01, 50);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_grant", int'({txe, rx, cnt0, cnt1, err}), int'({2'b11, 2'b00, 4'd0, 4'd0, 1'b0}));
    repeat (2) @(negedge clk);
    tx  = 2'b00;
    check("rst_held", int'({txe, rx, cnt0, cnt1, err}), int'({2'b11, 2'b00, 4'd0, 4'd0, 1'b0}));
    rst = 1'b0;
    model_last = 1'b1;
    mcnt[0] = 0;
    mcnt[1] = 0;
    repeat (3) @(negedge clk);

    // Both channels requesting continuously: strict alternation from channel 0.
    grant_q.delete();
    run_tokens(2, 2, 0, 500);
    check("alt_grants", grant_q.size(), 4);
    for (int i = 0; i < 4 && i < grant_q.size(); i++) begin
      check($sformatf("alt_order%0d", i), grant_q[i], i % 2);
    end
    check("alt_cnt0", int'(cnt0), 2);
    check("alt_cnt1", int'(cnt1), 2);

    // Counter wrap: 17 tokens on channel 1 with CNT_W=4.
    do_reset();
    run_tokens(0, 17, 1, 3000);
    check("wrap_cnt1", int'(cnt1), 1);
    check("wrap_cnt0", int'(cnt0), 0);

    // Winner withdraws its token during GRANT.
    do_reset();
    tx  = 2'b01;
    rxe = 1'b1;
    wait_out("err_enter_grant", 0, 2'b01, 50);
    tx = 2'b00;
    repeat (4) @(negedge clk);
    check("err_set", int'(err), 1);
    check("err_no_count", int'(cnt0), 0);
    rxe = 1'b0;
    wait_out("err_txe_low", 1, 2'b10, 50);
    wait_out("err_rx_low", 0, 2'b00, 50);
    rxe = 1'b1;
    wait_out("err_txe_high", 1, 2'b11, 50);
    repeat (10) @(negedge clk);
    check("err_single_count", int'(cnt0), 1);
    check("err_sticky", int'(err), 1);
    check("err_cnt1", int'(cnt1), 0);
    do_reset();
    check("err_cleared", int'(err), 0);

    // Randomized traffic against the token-level model; counters keep
    // accumulating (and wrapping) across runs.
    for (int r = 0; r < 8; r++) begin
      run_tokens($urandom_range(0, 8), $urandom_range(0, 8), $urandom_range(0, 4), 3000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/qdi_sync_arbiter.md
# qdi_sync_arbiter

Clocked two-way arbiter that acts as the responder for the arbiter bench's two 1-of-1 request channels and as the initiator on its 1-of-2 dual-rail grant channel. Each accepted request token produces exactly one dual-rail grant token naming the winning channel. The four-phase QDI handshake is completed on both sides. The block lets synchronous logic stand in for the asynchronous arbiter, so the existing Bin2QDI_1of1 transmitters and the QDI2Bin_1of2 receiver can drive and check it unchanged.

## Interface
- SYNC_STAGES, 2: synchronizer flops on each asynchronous input (Tx[1:0], Rxe). 0 means the inputs are already synchronous to CLK.
- CNT_W, 16: width of the per-channel grant counters.
- CLK  input  1  sole clock; all state changes on its rising edge.
- RESET  input  1  synchronous, active-high reset.
- Tx  input  2  1-of-1 request rails; Tx[k]=1 is a token on channel k.
- Txe  output  2  request-side enables; 1 = ready for a token, falling edge = acknowledge.
- Rx  output  2  dual-rail grant; Rx[0] = channel 0 won, Rx[1] = channel 1 won; never 2'b11.
- Rxe  input  1  grant-side enable from the receiver; 1 = ready, falling edge = acknowledge.
- GRANT_CNT0, GRANT_CNT1  output  CNT_W  tokens granted per channel; wrap modulo 2^CNT_W.
- PROTO_ERR  output  1  sticky; set on a request-side protocol violation.

## Operation
- All outputs are registered. Reset values: Txe=2'b11, Rx=2'b00, GRANT_CNT0=GRANT_CNT1=0, PROTO_ERR=0, state=IDLE, last=1, so channel 0 wins the first tie.
- FSM states: IDLE, GRANT, ACK, RELEASE. `w` is the winning channel, latched on leaving IDLE.
- IDLE: if Rxe=1 and any Tx[k]=1, pick the winner:
  - if one channel is requesting, it wins;
  - if both are requesting, the channel other than `last` wins.
  - Then set Rx[w]=1, latch w, set last=w, and go to GRANT.
  - If Rxe=0, the block holds in IDLE and nothing is granted.
- GRANT: wait for Rxe=0. Then drive Txe[w]=0, increment GRANT_CNTw, and go to ACK.
- ACK: wait for Tx[w]=0. Then drive Rx=2'b00 and go to RELEASE.
- RELEASE: wait for Rxe=1. Then drive Txe[w]=1 and go to IDLE.
- Fairness:
  - The loser's Tx stays high and its Txe stays 1 throughout; it wins in the next IDLE pass.
  - Under continuous requests from both channels, grants alternate 0,1,0,1,…
- A request arriving at any time other than IDLE is held by its sender and evaluated in the next IDLE.
- Protocol errors set PROTO_ERR, which clears only on RESET:
  - Tx[w] falls while in GRANT;
  - the non-winning Tx[k] falls while Txe[k]=1 after having been sampled high.
- Erroneous inputs never cause Rx=2'b11 and never cause a double count.
- RESET mid-handshake: every output and all state return to reset values on the next edge. Synchronizer flops are also cleared to 0.

## Timing
- With SYNC_STAGES=0, each FSM transition and its output update occur on the first rising edge at which the wait condition is sampled true.
- Single uncontended token, with each input answered one cycle after the block's output changes: Tx up at edge n gives Rx[w] at n+1, Txe[w] low at n+3, Rx low at n+5, Txe[w] high at n+7.
- Each asynchronous input adds SYNC_STAGES cycles to the transition that waits on it.
- Grants are back-to-back: a new grant can assert on the edge after Txe returns high, at the earliest.
- Rx changes only in IDLE→GRANT (rise) and ACK→RELEASE (fall). Txe changes only in GRANT→ACK (fall) and RELEASE→IDLE (rise).
- Counter wraps from 2^CNT_W−1 to 0 with no flag.

## Structure
- Package qdi_pkg holds:
  - the state enum (IDLE, GRANT, ACK, RELEASE);
  - NUM_CH=2;
  - dual-rail encodings DR_NULL=2'b00, DR_0=2'b01, DR_1=2'b10.
- Sub-module qdi_input_sync: SYNC_STAGES-deep flop chain with synchronous reset. It is instantiated for Tx[0], Tx[1] and Rxe, and is a pass-through when SYNC_STAGES=0.
- The arbiter FSM, round-robin pointer, counters and error logic live in the top module.

## Test plan
- Reset check: assert RESET for 3 cycles mid-GRANT → next edge gives Txe=11, Rx=00, counters 0, PROTO_ERR=0.
- Single token on channel 0 with a responsive receiver → Rx=01 once, full handshake completes, GRANT_CNT0=1, Txe returns to 11.
- Simultaneous Tx=11 held for 4 tokens → grant order 0,1,0,1; GRANT_CNT0=GRANT_CNT1=2; Rx never 11.
- Rxe held 0 after reset while Tx[1]=1 → Rx stays 00 for 20 cycles; raising Rxe gives Rx=10 after 1+SYNC_STAGES edges.
- Tx[0] dropped during GRANT → PROTO_ERR=1 and stays 1 until RESET; no extra count.
- With CNT_W=4, 17 tokens on channel 1 → GRANT_CNT1=1 (wrap), with no other side effect.
